// File: rtl/parity_pkg.sv
// parity_pkg: receiver FSM state encoding and shared error-counter width.
package parity_pkg;
  localparam int ERR_COUNT_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
endpackage

// File: rtl/parity_tree.sv
// parity_tree: combinational XOR reduction over a data word, shared by rx and tx.
module parity_tree #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  output logic             o_parity
);
  assign o_parity = ^i_data;
endmodule

// File: rtl/parity_check_rx.sv
// parity_check_rx: serial frame receiver (start, data LSB first, parity, stop) with parity/framing check and saturating error count.
module parity_check_rx
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_bit,
  input  logic                       rx_en,
  input  logic                       err_clr,
  input  logic                       err_load,
  input  logic [ERR_COUNT_WIDTH-1:0] err_load_val,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       data_valid,
  output logic                       parity_err,
  output logic                       frame_err,
  output logic [ERR_COUNT_WIDTH-1:0] err_count,
  output logic                       busy
);
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  rx_state_t                  r_state;
  logic [CW-1:0]              r_cnt;
  logic [DATA_WIDTH-1:0]      r_shift;
  logic [DATA_WIDTH-1:0]      r_data;
  logic                       r_par;
  logic                       r_valid;
  logic                       r_perr;
  logic                       r_ferr;
  logic [ERR_COUNT_WIDTH-1:0] r_err_cnt;
  logic                       w_data_par;
  logic                       w_stop;
  logic                       w_perr;
  logic                       w_bad;
  parity_tree #(.WIDTH(DATA_WIDTH)) u_tree (
    .i_data   (r_shift),
    .o_parity (w_data_par)
  );
  assign w_stop = rx_en && r_state == STOP;
  assign w_perr = w_data_par ^ r_par ^ ODD_PARITY;
  assign w_bad  = w_perr | ~rx_bit;
  // Results are registered on the stop strobe so they appear together with the valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_par     <= 1'b0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_valid <= w_stop;
      if (rx_en) begin
        case (r_state)
          IDLE: begin
            if (!rx_bit) begin
              r_state <= DATA;
              r_cnt   <= '0;
            end
          end
          DATA: begin
            r_shift[r_cnt] <= rx_bit;
            r_cnt          <= r_cnt + 1'b1;
            if (r_cnt == CW'(DATA_WIDTH - 1)) r_state <= PARITY;
          end
          PARITY: begin
            r_par   <= rx_bit;
            r_state <= STOP;
          end
          default: begin
            r_state <= IDLE;
            r_data  <= r_shift;
            r_perr  <= w_perr;
            r_ferr  <= ~rx_bit;
          end
        endcase
      end
      if (err_clr) r_err_cnt <= '0;
      else if (err_load) r_err_cnt <= err_load_val;
      else if (w_stop && w_bad && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end
  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign err_count  = r_err_cnt;
  assign busy       = r_state != IDLE;
endmodule

// File: tb/tb_parity_check_rx.sv
// tb_parity_check_rx: directed frames against a frame-level model checked every cycle.
module tb_parity_check_rx;
  localparam bit ODD = 1'b0;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_bit = 1'b1;
  logic        rx_en = 1'b0;
  logic        err_clr = 1'b0;
  logic        err_load = 1'b0;
  logic [15:0] err_load_val = '0;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        parity_err;
  logic        frame_err;
  logic [15:0] err_count;
  logic        busy;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          chk_on = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_perr;
  logic        m_ferr;
  logic        m_busy;
  logic [15:0] m_cnt;
  int          lat;
  logic        busy_all;
  always #5 clk = ~clk;
  parity_check_rx #(.DATA_WIDTH(8), .ODD_PARITY(ODD)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_bit       (rx_bit),
    .rx_en        (rx_en),
    .err_clr      (err_clr),
    .err_load     (err_load),
    .err_load_val (err_load_val),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .err_count    (err_count),
    .busy         (busy)
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (chk_on) begin
      chk("data_valid", {31'b0, data_valid}, {31'b0, m_valid});
      chk("data_out", {24'b0, data_out}, {24'b0, m_data});
      chk("parity_err", {31'b0, parity_err}, {31'b0, m_perr});
      chk("frame_err", {31'b0, frame_err}, {31'b0, m_ferr});
      chk("err_count", {16'b0, err_count}, {16'b0, m_cnt});
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
    end
  end
  task automatic tick(input logic en, input logic b, input logic clr, input logic rst,
                      input logic ld, input logic [15:0] v);
    rx_en = en;
    rx_bit = b;
    err_clr = clr;
    reset = rst;
    err_load = ld;
    err_load_val = v;
    @(posedge clk);
    #1;
    rx_en = 1'b0;
    err_clr = 1'b0;
    reset = 1'b0;
    err_load = 1'b0;
    m_valid = 1'b0;
    if (rst) begin
      m_data = '0;
      m_perr = 1'b0;
      m_ferr = 1'b0;
      m_cnt = '0;
      m_busy = 1'b0;
    end else if (clr) m_cnt = '0;
    else if (ld) m_cnt = v;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask
  // Drives one whole frame; gap = idle cycles between strobes; lat = ticks from start strobe to data_valid.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gap,
                            input logic clr_stop, output int lat_o, output logic busy_o);
    logic [10:0] bits;
    int t;
    bits = {s, p, d, 1'b0};
    lat_o = 0;
    busy_o = 1'b1;
    t = 0;
    for (int k = 0; k < 11; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) begin
          tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
          t++;
          if (!busy) busy_o = 1'b0;
        end
      end
      tick(1'b1, bits[k], clr_stop && k == 10, 1'b0, 1'b0, 16'h0);
      t++;
      if (k < 10) begin
        m_busy = 1'b1;
        if (!busy) busy_o = 1'b0;
      end else begin
        m_valid = 1'b1;
        m_busy = 1'b0;
        m_data = d;
        m_perr = (($countones(d) + int'(p) + int'(ODD)) % 2) != 0;
        m_ferr = !s;
        if (!clr_stop && (m_perr || m_ferr) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      if (lat_o == 0 && data_valid) lat_o = t;
    end
  endtask
  initial begin
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    chk_on = 1'b1;
    chk("rst_data", {24'b0, data_out}, 32'h0);
    chk("rst_valid", {31'b0, data_valid}, 32'h0);
    chk("rst_cnt", {16'b0, err_count}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("idle_mark_busy", {31'b0, busy}, 32'h0);
    send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0, lat, busy_all);
    chk("a5_latency", lat, 11);
    chk("a5_data", {24'b0, data_out}, 32'hA5);
    chk("a5_perr", {31'b0, parity_err}, 32'h0);
    chk("a5_ferr", {31'b0, frame_err}, 32'h0);
    chk("a5_cnt", {16'b0, err_count}, 32'h0);
    idle(2);
    chk("hold_data", {24'b0, data_out}, 32'hA5);
    send_frame(8'h07, 1'b0, 1'b1, 0, 1'b0, lat, busy_all);
    chk("p07_perr", {31'b0, parity_err}, 32'h1);
    chk("p07_ferr", {31'b0, frame_err}, 32'h0);
    chk("p07_cnt", {16'b0, err_count}, 32'h1);
    idle(1);
    send_frame(8'h07, 1'b0, 1'b0, 0, 1'b0, lat, busy_all);
    chk("f07_perr", {31'b0, parity_err}, 32'h1);
    chk("f07_ferr", {31'b0, frame_err}, 32'h1);
    chk("f07_cnt", {16'b0, err_count}, 32'h2);
    idle(1);
    send_frame(8'h3C, 1'b0, 1'b1, 1, 1'b0, lat, busy_all);
    chk("g3c_data", {24'b0, data_out}, 32'h3C);
    chk("g3c_perr", {31'b0, parity_err}, 32'h0);
    chk("g3c_ferr", {31'b0, frame_err}, 32'h0);
    chk("g3c_busy", {31'b0, busy_all}, 32'h1);
    send_frame(8'h55, 1'b0, 1'b1, 0, 1'b0, lat, busy_all);
    send_frame(8'hF0, 1'b1, 1'b1, 0, 1'b0, lat, busy_all);
    chk("b2b_latency", lat, 11);
    chk("b2b_data", {24'b0, data_out}, 32'hF0);
    chk("b2b_perr", {31'b0, parity_err}, 32'h1);
    chk("b2b_cnt", {16'b0, err_count}, 32'h3);
    idle(1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    m_busy = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("abort_valid", {31'b0, data_valid}, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_data", {24'b0, data_out}, 32'h0);
    chk("abort_cnt", {16'b0, err_count}, 32'h0);
    idle(12);
    send_frame(8'h81, 1'b0, 1'b1, 0, 1'b0, lat, busy_all);
    chk("r81_data", {24'b0, data_out}, 32'h81);
    chk("r81_perr", {31'b0, parity_err}, 32'h0);
    idle(1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFE);
    send_frame(8'h07, 1'b0, 1'b1, 0, 1'b0, lat, busy_all);
    chk("sat_reach", {16'b0, err_count}, 32'hFFFF);
    send_frame(8'h07, 1'b0, 1'b1, 0, 1'b0, lat, busy_all);
    chk("sat_hold", {16'b0, err_count}, 32'hFFFF);
    send_frame(8'h01, 1'b0, 1'b1, 0, 1'b0, lat, busy_all);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("clr_at_valid", {16'b0, err_count}, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0005);
    send_frame(8'h07, 1'b0, 1'b0, 0, 1'b1, lat, busy_all);
    chk("clr_wins_valid", {31'b0, data_valid}, 32'h1);
    chk("clr_wins_cnt", {16'b0, err_count}, 32'h0);
    idle(3);
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end, time %0t limit 100000", $time);
    $fatal(1);
  end
endmodule
